// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-2 Booth sequential multiplier.
// Optional BCD output path is enabled with the BOOTH_BCD_EN macro.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    CONV,
    DONE
  } state_t;

  // Booth recoding of {multiplier LSB, previous LSB}
  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // Decimal digits needed for a 2n-bit magnitude (log10(2) ~ 0.30103)
  function automatic int bcd_digits(input int n);
    return (2 * n * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_seq_conv.sv
// Sequential double-dabble binary-to-BCD converter: one bit per clock, W clocks per conversion.
// Used by booth_seq_mult only when BOOTH_BCD_EN is defined.
module bcd_seq_conv #(
  parameter int W = 16,
  parameter int D = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic [W-1:0]   bin,
  output logic           busy,
  output logic [4*D-1:0] bcd
);

  localparam int CW = $clog2(W);

  logic [W-1:0]   bin_sr;
  logic [4*D-1:0] dig_sr;
  logic [4*D-1:0] dig_adj;
  logic [4*D-1:0] dig_shift;
  logic [CW-1:0]  cnt;

  always_comb begin
    dig_adj = dig_sr;
    for (int i = 0; i < D; i++) begin
      if (dig_sr[4*i +: 4] >= 4'd5) begin
        dig_adj[4*i +: 4] = dig_sr[4*i +: 4] + 4'd3;
      end
    end
    dig_shift = {dig_adj[4*D-2:0], bin_sr[W-1]};
  end

  // The output register only changes on the final shift, so bcd never shows partial digits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_sr <= '0;
      dig_sr <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      bcd    <= '0;
    end else if (go) begin
      bin_sr <= bin;
      dig_sr <= '0;
      cnt    <= CW'(W - 1);
      busy   <= 1'b1;
    end else if (busy) begin
      dig_sr <= dig_shift;
      bin_sr <= {bin_sr[W-2:0], 1'b0};
      if (cnt == '0) begin
        busy <= 1'b0;
        bcd  <= dig_shift;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Radix-2 Booth sequential signed multiplier with start/done handshake, one iteration per clock.
// Define BOOTH_BCD_EN to add the neg/bcd display outputs and the CONV state.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter  int N      = 8,
  localparam int DIGITS = bcd_digits(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N-1:0]      a,
  input  logic [N-1:0]      b,
  output logic              busy,
  output logic              done,
  output logic [2*N-1:0]    y
`ifdef BOOTH_BCD_EN
  ,
  output logic              neg,
  output logic [4*DIGITS-1:0] bcd
`endif
);

  localparam int CW = $clog2(2 * N);

  state_t            state;
  logic [N:0]        m;
  logic [N:0]        hq;
  logic [N-1:0]      lq;
  logic              q_1;
  logic [CW-1:0]     cnt;

  logic [N:0]        sum;
  logic signed [2*N+1:0] acc_cat;
  logic [2*N+1:0]    shifted;
  logic [2*N-1:0]    prod_next;

  // HQ carries one guard bit so subtracting the most negative M cannot overflow
  always_comb begin
    case ({lq[0], q_1})
      BOOTH_ADD: sum = hq + m;
      BOOTH_SUB: sum = hq - m;
      default:   sum = hq;
    endcase
    acc_cat   = {sum, lq, q_1};
    shifted   = acc_cat >>> 1;
    prod_next = shifted[2*N:1];
  end

`ifdef BOOTH_BCD_EN
  logic [2*N-1:0] mag_next;
  logic           conv_go;
  logic           conv_busy;

  // Conversion is launched on the same edge that writes y, using the not-yet-registered product
  assign mag_next = prod_next[2*N-1] ? (~prod_next + 1'b1) : prod_next;
  assign conv_go  = (state == CALC) && (cnt == '0);

  bcd_seq_conv #(
    .W(2 * N),
    .D(DIGITS)
  ) u_conv (
    .clk (clk),
    .rst (rst),
    .go  (conv_go),
    .bin (mag_next),
    .busy(conv_busy),
    .bcd (bcd)
  );
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      m     <= '0;
      hq    <= '0;
      lq    <= '0;
      q_1   <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      y     <= '0;
`ifdef BOOTH_BCD_EN
      neg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m     <= {a[N-1], a};
            lq    <= b;
            hq    <= '0;
            q_1   <= 1'b0;
            cnt   <= CW'(N - 1);
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          hq  <= shifted[2*N+1:N+1];
          lq  <= shifted[N:1];
          q_1 <= shifted[0];
          if (cnt == '0) begin
            y <= prod_next;
`ifdef BOOTH_BCD_EN
            cnt   <= CW'(2 * N - 1);
            state <= CONV;
`else
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef BOOTH_BCD_EN
        CONV: begin
          // The converter finishes on the same edge our counter expires
          if (cnt == '0 && conv_busy) begin
            neg   <= y[2*N-1];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult: N=8 and N=4 instances, scoreboard of expected products.
// Honours BOOTH_BCD_EN (longer latency plus neg/bcd checks).
module tb_booth_seq_mult;

`ifdef BOOTH_BCD_EN
  localparam int LAT_MUL = 3;
`else
  localparam int LAT_MUL = 1;
`endif

  typedef struct {
    logic [15:0] y;
    logic        neg;
    logic [19:0] bcd;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   edges, dones, pushes, next_acc, av, bv;

  logic        clk, rst;
  logic        start8, start4;
  logic [7:0]  a8, b8;
  logic [3:0]  a4, b4;
  logic        busy8, done8, busy4, done4;
  logic [15:0] y8;
  logic [7:0]  y4;
`ifdef BOOTH_BCD_EN
  logic        neg8, neg4;
  logic [19:0] bcd8;
  logic [11:0] bcd4;
`endif

  booth_seq_mult #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .y(y8)
`ifdef BOOTH_BCD_EN
    , .neg(neg8), .bcd(bcd8)
`endif
  );

  booth_seq_mult #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .y(y4)
`ifdef BOOTH_BCD_EN
    , .neg(neg4), .bcd(bcd4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input int x, input int z, input int w);
    exp_t r;
    int   p, mag;
    p = x * z;
    r.y   = (w == 4) ? {8'h00, p[7:0]} : p[15:0];
    r.neg = (p < 0);
    mag   = (p < 0) ? -p : p;
    r.bcd = '0;
    for (int d = 0; d < 5; d++) begin
      r.bcd[4*d +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge following the accepting edge
  task automatic apply_stimulus(input bit use4, input int x, input int z);
    if (use4) begin
      a4 = 4'(x); b4 = 4'(z); start4 = 1'b1;
    end else begin
      a8 = 8'(x); b8 = 8'(z); start8 = 1'b1;
    end
    sb_q.push_back(model(x, z, use4 ? 4 : 8));
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
    check_output({"busy_after_start"}, 32'(use4 ? busy4 : busy8), 32'd1);
  endtask

  task automatic wait_result(input bit use4, input string tag);
    exp_t r;
    int   n;
    n = 0;
    while (n < 200 && !(use4 ? done4 : done8)) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_done"}, 32'(use4 ? done4 : done8), 32'd1);
    check_output({tag, "_latency"}, 32'(n), 32'((use4 ? 4 : 8) * LAT_MUL));
    check_output({tag, "_busy_in_done"}, 32'(use4 ? busy4 : busy8), 32'd0);
    if (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      check_output({tag, "_y"}, use4 ? {24'h0, y4} : {16'h0, y8}, {16'h0, r.y});
`ifdef BOOTH_BCD_EN
      check_output({tag, "_neg"}, 32'(use4 ? neg4 : neg8), 32'(r.neg));
      check_output({tag, "_bcd"}, use4 ? 32'(bcd4) : 32'(bcd8), 32'(r.bcd));
`endif
    end
    @(negedge clk);
    check_output({tag, "_done_pulse"}, 32'(use4 ? done4 : done8), 32'd0);
  endtask

  initial begin
    rst = 1'b0; start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    $display("[TB] reset phase");
    repeat (3) @(negedge clk);
    check_output("rst_busy", 32'(busy8), 32'd0);
    check_output("rst_done", 32'(done8), 32'd0);
    check_output("rst_y", 32'(y8), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] basic products");
    apply_stimulus(0, 3, 5);        wait_result(0, "p3x5");
    apply_stimulus(0, -128, -128);  wait_result(0, "pmin_sq");
    apply_stimulus(0, -128, 127);   wait_result(0, "pmin_max");
    apply_stimulus(0, 0, -1);       wait_result(0, "pzero");
    apply_stimulus(0, -128, 127);   wait_result(0, "pmin_max2");

    $display("[TB] start held with changing operands");
    next_acc = 0; dones = 0; pushes = 0;
    for (int c = 0; c < 80; c++) begin
      start8 = (c < 20);
      a8 = 8'(c * 37 + 5);
      b8 = 8'(c * 11 - 60);
      if (c < 20 && c == next_acc) begin
        av = $signed(a8);
        bv = $signed(b8);
        sb_q.push_back(model(av, bv, 8));
        pushes++;
        next_acc = c + 8 * LAT_MUL + 2;
      end
      @(negedge clk);
      if (done8 && sb_q.size() > 0) begin
        dones++;
        e = sb_q.pop_front();
        check_output("held_y", 32'(y8), 32'(e.y));
      end else if (done8) begin
        dones++;
      end
    end
    start8 = 1'b0;
    check_output("held_done_count", 32'(dones), 32'(pushes));

    $display("[TB] reset mid-operation");
    apply_stimulus(0, 100, -3);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("abort_busy", 32'(busy8), 32'd0);
    check_output("abort_done", 32'(done8), 32'd0);
    check_output("abort_y", 32'(y8), 32'd0);
`ifdef BOOTH_BCD_EN
    check_output("abort_bcd", 32'(bcd8), 32'd0);
`endif
    void'(sb_q.pop_front());
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    apply_stimulus(0, -7, 9);       wait_result(0, "after_abort");

    $display("[TB] N=4 instance");
    apply_stimulus(1, 7, -8);       wait_result(1, "n4_7xm8");
    for (int i = -8; i < 8; i++) begin
      for (int j = -8; j < 8; j++) begin
        apply_stimulus(1, i, j);
        wait_result(1, "n4_sweep");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
